mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_dmem32.sv | 28 ++
 rtl/mem_stage.sv | 94 +++++++++
 tb/tb_mem_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline constants and the MEM/WB payload type for the MEM stage.
// Also holds the misaligned-access rule used when DMEM_ALIGN_CHK_EN is defined.
package mem_stage_pkg;

    localparam int unsigned DMEM_DEPTH = 32;
    localparam int unsigned DMEM_AW    = 5;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_AW     = 5;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [REG_AW-1:0] d;
        logic [WORD_W-1:0] alu;
        logic [WORD_W-1:0] mdo;
    } wb_pipe_t;

    // A store, or a load that will write back memory data, must be word aligned
    function automatic logic is_misaligned(
        input logic [1:0] byte_off,
        input logic       wmem,
        input logic       wreg,
        input logic       m2reg
    );
        return (byte_off != 2'b00) && (wmem || (wreg && m2reg));
    endfunction

endpackage

// File: rtl/mem_stage_dmem32.sv
// 32 x 32-bit data memory: asynchronous read, synchronous write, asynchronous clear.
// Read and write share one word index, so a same-cycle read returns the old word.
module dmem32
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               clrn,
    input  logic               we,
    input  logic [DMEM_AW-1:0] addr,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata
);

    logic [WORD_W-1:0] mem_q [DMEM_DEPTH];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory access plus the MEM/WB pipeline register.
// Define DMEM_ALIGN_CHK_EN to suppress misaligned stores and raise a sticky align_err.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              clrn,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic              mem_wmem,
    input  logic [REG_AW-1:0] mem_d,
    input  logic [WORD_W-1:0] mem_alu,
    input  logic [WORD_W-1:0] mem_s,
    output logic [WORD_W-1:0] mdo,
    output logic              wb_wreg,
    output logic              wb_m2reg,
    output logic [REG_AW-1:0] wb_d,
    output logic [WORD_W-1:0] wb_alu,
    output logic [WORD_W-1:0] wb_mdo,
    output logic [WORD_W-1:0] wb_data,
    output logic              align_err
);

    logic [DMEM_AW-1:0] word_idx_c;
    logic               misalign_c;
    logic               store_en_c;
    wb_pipe_t           wb_next_c;
    wb_pipe_t           wb_q;

    // Upper address bits are ignored: the memory image repeats every 128 bytes
    assign word_idx_c = mem_alu[DMEM_AW+1:2];

`ifdef DMEM_ALIGN_CHK_EN
    logic align_err_q;
    logic unused_addr_hi;

    assign misalign_c     = is_misaligned(mem_alu[1:0], mem_wmem, mem_wreg, mem_m2reg);
    assign unused_addr_hi = ^mem_alu[WORD_W-1:DMEM_AW+2];

    // Sticky until reset; further misaligned cycles only keep it set
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            align_err_q <= 1'b0;
        end else if (misalign_c) begin
            align_err_q <= 1'b1;
        end
    end

    assign align_err = align_err_q;
`else
    logic unused_addr_bits;

    assign misalign_c       = 1'b0;
    assign unused_addr_bits = ^{mem_alu[WORD_W-1:DMEM_AW+2], mem_alu[1:0]};
    assign align_err        = 1'b0;
`endif

    assign store_en_c = mem_wmem & ~misalign_c;

    dmem32 u_dmem (
        .clk   (clk),
        .clrn  (clrn),
        .we    (store_en_c),
        .addr  (word_idx_c),
        .wdata (mem_s),
        .rdata (mdo)
    );

    // Control bits pass through untouched; mdo is the pre-write word
    always_comb begin
        wb_next_c       = '0;
        wb_next_c.wreg  = mem_wreg;
        wb_next_c.m2reg = mem_m2reg;
        wb_next_c.d     = mem_d;
        wb_next_c.alu   = mem_alu;
        wb_next_c.mdo   = mdo;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_next_c;
        end
    end

    assign wb_wreg  = wb_q.wreg;
    assign wb_m2reg = wb_q.m2reg;
    assign wb_d     = wb_q.d;
    assign wb_alu   = wb_q.alu;
    assign wb_mdo   = wb_q.mdo;
    assign wb_data  = wb_q.m2reg ? wb_q.mdo : wb_q.alu;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a word-array reference model of the data memory.
module tb_mem_stage;

`ifdef DMEM_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        clrn;
    logic        mem_wreg;
    logic        mem_m2reg;
    logic        mem_wmem;
    logic [4:0]  mem_d;
    logic [31:0] mem_alu;
    logic [31:0] mem_s;
    logic [31:0] mdo;
    logic        wb_wreg;
    logic        wb_m2reg;
    logic [4:0]  wb_d;
    logic [31:0] wb_alu;
    logic [31:0] wb_mdo;
    logic [31:0] wb_data;
    logic        align_err;

    int n_vec;
    int n_err;

    // Reference model state
    logic [31:0] ref_mem [32];
    logic        ref_align;
    logic        ref_wreg;
    logic        ref_m2reg;
    logic [4:0]  ref_d;
    logic [31:0] ref_alu;
    logic [31:0] ref_mdo;
    logic [31:0] pred_mdo;
    logic [31:0] obs_mdo;

    mem_stage dut (
        .clk       (clk),
        .clrn      (clrn),
        .mem_wreg  (mem_wreg),
        .mem_m2reg (mem_m2reg),
        .mem_wmem  (mem_wmem),
        .mem_d     (mem_d),
        .mem_alu   (mem_alu),
        .mem_s     (mem_s),
        .mdo       (mdo),
        .wb_wreg   (wb_wreg),
        .wb_m2reg  (wb_m2reg),
        .wb_d      (wb_d),
        .wb_alu    (wb_alu),
        .wb_mdo    (wb_mdo),
        .wb_data   (wb_data),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        ref_align = 1'b0;
        ref_wreg  = 1'b0;
        ref_m2reg = 1'b0;
        ref_d     = 5'd0;
        ref_alu   = 32'h0;
        ref_mdo   = 32'h0;
    endfunction

    // Apply one cycle of inputs; sample mdo mid-cycle and advance the model at the edge
    task automatic drive_cycle(input logic wreg, input logic m2reg, input logic wmem,
                               input logic [4:0] d, input logic [31:0] alu, input logic [31:0] s);
        int  idx;
        bit  mis;
        mem_wreg  = wreg;
        mem_m2reg = m2reg;
        mem_wmem  = wmem;
        mem_d     = d;
        mem_alu   = alu;
        mem_s     = s;
        idx       = int'((alu % 128) / 4);
        @(negedge clk);
        obs_mdo  = mdo;
        pred_mdo = ref_mem[idx];
        @(posedge clk);
        mis = CHK && (alu % 4 != 0) && (wmem || (wreg && m2reg));
        ref_wreg  = wreg;
        ref_m2reg = m2reg;
        ref_d     = d;
        ref_alu   = alu;
        ref_mdo   = pred_mdo;
        if (wmem && !mis) ref_mem[idx] = s;
        if (mis) ref_align = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b1;
        mem_wreg = 0; mem_m2reg = 0; mem_wmem = 0;
        mem_d = 0; mem_alu = 0; mem_s = 0;
        #1 clrn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (wb_data !== 32'h0 || wb_alu !== 32'h0 || wb_mdo !== 32'h0) begin
            n_err++;
            $display("FAIL reset_wb: wb_data=%h wb_alu=%h wb_mdo=%h required all 0", wb_data, wb_alu, wb_mdo);
        end
        n_vec++;
        if (wb_wreg !== 1'b0 || wb_m2reg !== 1'b0 || wb_d !== 5'd0 || align_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl: wreg=%b m2reg=%b d=%0d align_err=%b required 0", wb_wreg, wb_m2reg, wb_d, align_err);
        end
        n_vec++;
        if (mdo !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mdo: got %h required 0", mdo);
        end
        clrn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd0, 32'h8, 32'hDEADBEEF);
        n_vec++;
        if (wb_wreg !== 1'b0) begin
            n_err++;
            $display("FAIL store_wb_wreg: got %b required 0", wb_wreg);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 5'd5, 32'h8, 32'h0);
        n_vec++;
        if (obs_mdo !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL load_mdo: got %h required deadbeef", obs_mdo);
        end
        n_vec++;
        if (wb_data !== 32'hDEADBEEF || wb_d !== 5'd5 || wb_wreg !== 1'b1) begin
            n_err++;
            $display("FAIL load_wb: wb_data=%h wb_d=%0d wb_wreg=%b required deadbeef/5/1", wb_data, wb_d, wb_wreg);
        end
    endtask

    task automatic test_passthrough();
        drive_cycle(1'b1, 1'b0, 1'b0, 5'd3, 32'h1234, 32'h0);
        n_vec++;
        if (wb_data !== 32'h1234 || wb_wreg !== 1'b1 || wb_d !== 5'd3 || wb_m2reg !== 1'b0) begin
            n_err++;
            $display("FAIL passthrough: wb_data=%h wreg=%b d=%0d m2reg=%b required 1234/1/3/0",
                     wb_data, wb_wreg, wb_d, wb_m2reg);
        end
    endtask

    task automatic test_wrap_same_cycle();
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd0, 32'h4, 32'h11);
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd0, 32'h84, 32'h22);
        n_vec++;
        if (obs_mdo !== 32'h11) begin
            n_err++;
            $display("FAIL wrap_old_mdo: got %h required 11", obs_mdo);
        end
        n_vec++;
        if (wb_mdo !== 32'h11) begin
            n_err++;
            $display("FAIL wrap_wb_mdo: got %h required 11", wb_mdo);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 5'd1, 32'h4, 32'h0);
        n_vec++;
        if (obs_mdo !== 32'h22) begin
            n_err++;
            $display("FAIL wrap_new_mdo: got %h required 22", obs_mdo);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 5'd7, 32'hFFFFFFFF, 32'h0);
        n_vec++;
        if (wb_alu !== 32'hFFFFFFFF) begin
            n_err++;
            $display("FAIL areset_pre: wb_alu=%h required ffffffff", wb_alu);
        end
        #2 clrn = 1'b0;
        #1;
        n_vec++;
        if (wb_wreg !== 1'b0 || wb_m2reg !== 1'b0 || wb_d !== 5'd0 || wb_alu !== 32'h0 ||
            wb_mdo !== 32'h0 || wb_data !== 32'h0) begin
            n_err++;
            $display("FAIL areset_immediate: wreg=%b m2reg=%b d=%0d alu=%h mdo=%h data=%h required all 0",
                     wb_wreg, wb_m2reg, wb_d, wb_alu, wb_mdo, wb_data);
        end
        // A store presented while reset is held must be dropped
        mem_wmem = 1'b1; mem_alu = 32'h8; mem_s = 32'hAAAA5555;
        @(posedge clk);
        #2 clrn = 1'b1;
        model_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 5'd2, 32'h8, 32'h0);
        n_vec++;
        if (obs_mdo !== 32'h0) begin
            n_err++;
            $display("FAIL areset_load: mdo=%h required 0", obs_mdo);
        end
        n_vec++;
        if (wb_data !== 32'h0) begin
            n_err++;
            $display("FAIL areset_wb_data: got %h required 0", wb_data);
        end
    endtask

    task automatic test_misalign();
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd0, 32'h6, 32'h55);
        n_vec++;
        if (align_err !== CHK) begin
            n_err++;
            $display("FAIL misalign_flag: got %b required %b", align_err, CHK);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 5'd4, 32'h4, 32'h0);
        n_vec++;
        if (obs_mdo !== (CHK ? 32'h0 : 32'h55)) begin
            n_err++;
            $display("FAIL misalign_dmem1: got %h required %h", obs_mdo, CHK ? 32'h0 : 32'h55);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 5'd0, 32'h10, 32'h77);
        drive_cycle(1'b1, 1'b1, 1'b0, 5'd1, 32'h10, 32'h0);
        n_vec++;
        if (align_err !== CHK || wb_data !== 32'h77) begin
            n_err++;
            $display("FAIL misalign_sticky: align_err=%b wb_data=%h required %b/77", align_err, wb_data, CHK);
        end
        #2 clrn = 1'b0;
        #1;
        n_vec++;
        if (align_err !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_clear: got %b required 0", align_err);
        end
        #2 clrn = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] alu;
        for (int n = 0; n < 300; n++) begin
            alu = $urandom;
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 31)), alu, $urandom);
            n_vec++;
            if (obs_mdo !== pred_mdo) begin
                n_err++;
                $display("FAIL rand_mdo[%0d]: got %h required %h", n, obs_mdo, pred_mdo);
            end
            n_vec++;
            if (wb_wreg !== ref_wreg || wb_m2reg !== ref_m2reg || wb_d !== ref_d ||
                wb_alu !== ref_alu || wb_mdo !== ref_mdo) begin
                n_err++;
                $display("FAIL rand_wb[%0d]: got %b %b %0d %h %h required %b %b %0d %h %h", n,
                         wb_wreg, wb_m2reg, wb_d, wb_alu, wb_mdo, ref_wreg, ref_m2reg, ref_d, ref_alu, ref_mdo);
            end
            n_vec++;
            if (wb_data !== (ref_m2reg ? ref_mdo : ref_alu) || align_err !== ref_align) begin
                n_err++;
                $display("FAIL rand_data[%0d]: wb_data=%h align_err=%b required %h/%b", n,
                         wb_data, align_err, ref_m2reg ? ref_mdo : ref_alu, ref_align);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_store_load();
        test_passthrough();
        test_wrap_same_cycle();
        test_async_reset();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
